// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data RAM between the CPU MEM stage and a
// DMA/debug requester; CPU first, with bounded DMA starvation and burst length.
module dm_arbiter #(
    parameter int AW        = 14,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_be,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          cpu_kill,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [3:0]    dma_be,
    input  logic [31:0]   dma_addr,
    input  logic [31:0]   dma_wdata,
    input  logic          dma_lock,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-3:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX_C  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE_C  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO_C = WAIT_W'(0);
    localparam logic [BEAT_W-1:0] BEAT_MAX_C  = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_ONE_C  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO_C = BEAT_W'(0);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_YIELD = 2'd2
    } arb_state_t;

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [BEAT_W-1:0] beat_cnt_nxt_s;
    logic [BEAT_W-1:0] beat_inc_s;
    logic              tag_valid_r;
    logic              tag_dma_r;
    logic              tag_valid_nxt_s;
    logic              tag_dma_nxt_s;
    logic              cpu_act_s;
    logic              dma_act_s;
    logic              wait_full_s;
    logic              arb_dma_s;
    logic              cpu_gnt_s;
    logic              dma_gnt_s;
    logic              addr_unused_s;

    // Byte strobes only reach the RAM for writes
    function automatic logic [3:0] wr_strobe(input logic we, input logic [3:0] be);
        return we ? be : 4'b0000;
    endfunction

    assign addr_unused_s = ^{cpu_addr[31:AW], cpu_addr[1:0], dma_addr[31:AW], dma_addr[1:0]};

    // Effective requests and the plain CPU-first decision; nothing is granted under reset
    always_comb begin
        cpu_act_s   = reset & cpu_req & ~cpu_kill;
        dma_act_s   = reset & dma_req;
        wait_full_s = (wait_cnt_r == WAIT_MAX_C);
        arb_dma_s   = dma_act_s & (~cpu_act_s | wait_full_s);
        if (beat_cnt_r >= BEAT_MAX_C) begin
            beat_inc_s = BEAT_MAX_C;
        end else begin
            beat_inc_s = beat_cnt_r + BEAT_ONE_C;
        end
    end

    // Grant selection and next state; a beat that reaches MAX_BURST with the CPU waiting hands over one slot
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        cpu_gnt_s      = 1'b0;
        dma_gnt_s      = 1'b0;
        case (state_r)
            ST_BURST: begin
                if (dma_act_s && dma_lock) begin
                    dma_gnt_s      = 1'b1;
                    beat_cnt_nxt_s = beat_inc_s;
                    if (cpu_act_s && (beat_inc_s == BEAT_MAX_C)) begin
                        state_nxt_s = ST_YIELD;
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end else begin
                    dma_gnt_s      = arb_dma_s;
                    cpu_gnt_s      = cpu_act_s & ~arb_dma_s;
                    state_nxt_s    = ST_ARB;
                    beat_cnt_nxt_s = BEAT_ZERO_C;
                end
            end
            ST_YIELD: begin
                cpu_gnt_s      = cpu_act_s;
                beat_cnt_nxt_s = BEAT_ZERO_C;
                if (dma_lock) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_ARB: begin
                dma_gnt_s = arb_dma_s;
                cpu_gnt_s = cpu_act_s & ~arb_dma_s;
                if (arb_dma_s && dma_lock) begin
                    beat_cnt_nxt_s = BEAT_ONE_C;
                    if (cpu_act_s && (BEAT_ONE_C == BEAT_MAX_C)) begin
                        state_nxt_s = ST_YIELD;
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end else begin
                    beat_cnt_nxt_s = BEAT_ZERO_C;
                    state_nxt_s    = ST_ARB;
                end
            end
            default: begin
                state_nxt_s    = ST_ARB;
                beat_cnt_nxt_s = BEAT_ZERO_C;
            end
        endcase
    end

    // DMA starvation counter and read-return tag for the next cycle
    always_comb begin
        wait_cnt_nxt_s  = WAIT_ZERO_C;
        tag_valid_nxt_s = (cpu_gnt_s & ~cpu_we) | (dma_gnt_s & ~dma_we);
        tag_dma_nxt_s   = dma_gnt_s;
        if (dma_req && !dma_gnt_s) begin
            if (wait_full_s) begin
                wait_cnt_nxt_s = WAIT_MAX_C;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE_C;
            end
        end else begin
            wait_cnt_nxt_s = WAIT_ZERO_C;
        end
    end

    // RAM port driven by whichever requester won this cycle
    always_comb begin
        ram_en    = cpu_gnt_s | dma_gnt_s;
        ram_we    = 4'b0000;
        ram_addr  = {(AW-2){1'b0}};
        ram_wdata = 32'h0000_0000;
        if (dma_gnt_s) begin
            ram_we    = wr_strobe(dma_we, dma_be);
            ram_addr  = dma_addr[AW-1:2];
            ram_wdata = dma_wdata;
        end else if (cpu_gnt_s) begin
            ram_we    = wr_strobe(cpu_we, cpu_be);
            ram_addr  = cpu_addr[AW-1:2];
            ram_wdata = cpu_wdata;
        end else begin
            ram_we    = 4'b0000;
        end
    end

    // Requester-facing status; a return still in flight when reset arrives is dropped
    always_comb begin
        cpu_stall  = cpu_act_s & ~cpu_gnt_s;
        dma_gnt    = dma_gnt_s;
        cpu_rvalid = reset & tag_valid_r & ~tag_dma_r;
        dma_rvalid = reset & tag_valid_r & tag_dma_r;
        cpu_rdata  = cpu_rvalid ? ram_rdata : 32'h0000_0000;
        dma_rdata  = dma_rvalid ? ram_rdata : 32'h0000_0000;
    end

    // State, starvation/burst counters and the read-return tag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_ARB;
            wait_cnt_r  <= WAIT_ZERO_C;
            beat_cnt_r  <= BEAT_ZERO_C;
            tag_valid_r <= 1'b0;
            tag_dma_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
            tag_valid_r <= tag_valid_nxt_s;
            tag_dma_r   <= tag_dma_nxt_s;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model with its own copy of the RAM.
module tb_dm_arbiter;

    localparam int AW        = 14;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;
    localparam int WORDS     = 1 << (AW - 2);

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_kill;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_lock;
    logic [3:0]  dma_be;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [AW-3:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_kill(cpu_kill), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Bench RAM: synchronous single port, read data one cycle after ram_en
    logic        preload = 1'b1;
    logic [31:0] ram_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner of the burst, beats taken, DMA losses, pending read, memory image
    logic        m_burst, m_yield, m_tag_v, m_tag_dma;
    int          m_beats, m_losses;
    logic [31:0] m_tag_data;
    logic [31:0] m_mem [0:WORDS-1];

    logic        obs_stall, obs_dma_gnt, obs_ram_en, obs_cpu_rvalid, obs_dma_rvalid;
    logic [3:0]  obs_ram_we;
    logic [31:0] obs_cpu_rdata, obs_dma_rdata;

    task automatic model_cycle();
        logic        cpu_e, dma_e, g_cpu, g_dma, s_we;
        logic [3:0]  s_be, exp_we;
        logic [31:0] s_addr, s_wdata;
        int          wa;
        cpu_e = reset && cpu_req && !cpu_kill;
        dma_e = reset && dma_req;
        g_cpu = 1'b0;
        g_dma = 1'b0;
        if (m_yield) g_cpu = cpu_e;
        else if (m_burst && dma_e && dma_lock) g_dma = 1'b1;
        else if (dma_e && (!cpu_e || m_losses == MAX_WAIT)) g_dma = 1'b1;
        else g_cpu = cpu_e;

        s_we    = g_dma ? dma_we    : cpu_we;
        s_be    = g_dma ? dma_be    : cpu_be;
        s_addr  = g_dma ? dma_addr  : cpu_addr;
        s_wdata = g_dma ? dma_wdata : cpu_wdata;
        wa      = int'(s_addr[AW-1:2]);
        exp_we  = ((g_cpu || g_dma) && s_we) ? s_be : 4'b0000;

        chk("cpu_stall", cpu_stall, cpu_e && !g_cpu);
        chk("dma_gnt", dma_gnt, g_dma);
        chk("ram_en", ram_en, g_cpu || g_dma);
        chk("ram_we", ram_we, exp_we);
        if (g_cpu || g_dma) chk("ram_addr", ram_addr, 32'(wa));
        if (exp_we != 4'b0000) chk("ram_wdata", ram_wdata, s_wdata);
        chk("cpu_rvalid", cpu_rvalid, reset && m_tag_v && !m_tag_dma);
        chk("dma_rvalid", dma_rvalid, reset && m_tag_v && m_tag_dma);
        if (reset && m_tag_v && !m_tag_dma) chk("cpu_rdata", cpu_rdata, m_tag_data);
        if (reset && m_tag_v && m_tag_dma)  chk("dma_rdata", dma_rdata, m_tag_data);

        obs_stall = cpu_stall;   obs_dma_gnt = dma_gnt;   obs_ram_en = ram_en;
        obs_ram_we = ram_we;     obs_cpu_rvalid = cpu_rvalid; obs_dma_rvalid = dma_rvalid;
        obs_cpu_rdata = cpu_rdata; obs_dma_rdata = dma_rdata;

        if (!reset) begin
            m_burst = 1'b0; m_yield = 1'b0; m_beats = 0; m_losses = 0;
            m_tag_v = 1'b0; m_tag_dma = 1'b0;
        end else begin
            m_tag_v   = (g_cpu || g_dma) && !s_we;
            m_tag_dma = g_dma;
            if (m_tag_v) m_tag_data = m_mem[wa];
            for (int b = 0; b < 4; b++)
                if (exp_we[b]) m_mem[wa][8*b +: 8] = s_wdata[8*b +: 8];
            if (dma_req && !g_dma) m_losses = (m_losses < MAX_WAIT) ? m_losses + 1 : MAX_WAIT;
            else m_losses = 0;
            if (m_yield) begin
                m_yield = 1'b0;
                m_burst = dma_lock;
                m_beats = 0;
            end else if (g_dma && dma_lock) begin
                m_beats = m_burst ? ((m_beats < MAX_BURST) ? m_beats + 1 : MAX_BURST) : 1;
                m_burst = 1'b1;
                if (cpu_e && m_beats == MAX_BURST) begin
                    m_yield = 1'b1;
                    m_burst = 1'b0;
                end
            end else begin
                m_burst = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_kill = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    endtask

    int first, ng, ns, dg, tail, stall_run, yield_at;
    logic yielded;
    logic [31:0] a;

    initial begin
        reset = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_we = 1'b0; dma_be = 4'h0; dma_addr = 32'h0; dma_wdata = 32'h0;
        idle();
        m_burst = 1'b0; m_yield = 1'b0; m_tag_v = 1'b0; m_tag_dma = 1'b0;
        m_beats = 0; m_losses = 0; m_tag_data = 32'h0;
        for (int i = 0; i < WORDS; i++) m_mem[i] = init_word(i);
        @(posedge clk); #1;
        preload = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        chk("reset_ram_en", obs_ram_en, 1'b0);
        chk("reset_rvalid", obs_cpu_rvalid | obs_dma_rvalid, 1'b0);

        // Write then read back the same word
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        step();
        cpu_we = 1'b0;
        step();
        chk("rw_stall", obs_stall, 1'b0);
        idle();
        step();
        chk("rw_rvalid", obs_cpu_rvalid, 1'b1);
        chk("rw_rdata", obs_cpu_rdata, 32'hDEADBEEF);
        step();
        chk("rw_rvalid_pulse", obs_cpu_rvalid, 1'b0);

        // DMA starved by a busy CPU is forced through on the fifth cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; dma_lock = 1'b0;
        first = 0; ng = 0; ns = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (obs_dma_gnt) begin ng++; if (first == 0) first = c; end
            if (obs_stall) ns++;
        end
        chk("wait_first_gnt", first, 5);
        chk("wait_gnt_count", ng, 2);
        chk("wait_stall_count", ns, 2);
        idle();
        step();

        // Locked 12-beat DMA write burst against a CPU requesting every cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
        dma_req = 1'b1; dma_we = 1'b1; dma_be = 4'hF; dma_lock = 1'b1;
        dg = 0; tail = 0; stall_run = 0; yield_at = 0; yielded = 1'b0;
        for (int c = 1; c <= 40 && dg < 12; c++) begin
            dma_addr  = 32'h100 + 32'(dg) * 32'd4;
            dma_wdata = 32'hB0000000 + 32'(dg);
            step();
            if (obs_dma_gnt) dg++;
            if (!yielded && dg > 0) begin
                if (obs_stall) stall_run++;
                else begin yielded = 1'b1; yield_at = dg; end
            end else if (yielded && obs_dma_gnt) tail++;
        end
        chk("burst_total", dg, 12);
        chk("burst_before_yield", yield_at, MAX_BURST);
        chk("burst_tail", tail, 4);
        chk("burst_stall_run", stall_run, MAX_BURST);
        idle();
        step();

        // Killed write leaves the RAM untouched
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_kill = 1'b1; cpu_be = 4'hF;
        cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
        step();
        chk("kill_ram_en", obs_ram_en, 1'b0);
        chk("kill_ram_we", obs_ram_we, 4'b0000);
        chk("kill_stall", obs_stall, 1'b0);
        cpu_kill = 1'b0; cpu_we = 1'b0;
        step();
        idle();
        step();
        chk("kill_rvalid", obs_cpu_rvalid, 1'b1);
        chk("kill_old_data", obs_cpu_rdata, init_word(12));

        // Reset right after a locked DMA read: return discarded, burst aborted
        dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b1; dma_addr = 32'h20;
        step();
        chk("rst_dma_gnt", obs_dma_gnt, 1'b1);
        idle();
        reset = 1'b0;
        step();
        chk("rst_no_rvalid", obs_dma_rvalid, 1'b0);
        reset = 1'b1;
        step();
        chk("rst_after_ram_en", obs_ram_en, 1'b0);
        chk("rst_after_rvalid", obs_dma_rvalid | obs_cpu_rvalid, 1'b0);
        chk("rst_after_rdata", obs_dma_rdata | obs_cpu_rdata, 32'h0);
        chk("rst_after_stall", obs_stall, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
        dma_req = 1'b1; dma_lock = 1'b1;
        step();
        chk("rst_arb_cpu_first", obs_dma_gnt, 1'b0);
        idle();
        step();

        // Partial byte write merges into the existing word
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h40; cpu_wdata = 32'h11223344;
        step();
        cpu_be = 4'b0100; cpu_wdata = 32'h00AB0000;
        step();
        cpu_we = 1'b0;
        step();
        idle();
        step();
        chk("byte_merge", obs_cpu_rdata, 32'h11AB3344);

        // Randomized traffic; DMA holds a request until it is granted
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 99) != 0);
            cpu_req  = ($urandom_range(0, 9) < 6);
            cpu_kill = ($urandom_range(0, 9) == 0);
            cpu_we   = 1'($urandom_range(0, 1));
            cpu_be   = 4'($urandom);
            cpu_wdata = $urandom;
            a = $urandom; a[AW-1:2] = 12'($urandom_range(0, 15)); cpu_addr = a;
            if (!dma_req || obs_dma_gnt || $urandom_range(0, 7) == 0) begin
                dma_req   = 1'($urandom_range(0, 1));
                dma_we    = 1'($urandom_range(0, 1));
                dma_be    = 4'($urandom);
                dma_wdata = $urandom;
                a = $urandom; a[AW-1:2] = 12'($urandom_range(0, 15)); dma_addr = a;
            end
            if ($urandom_range(0, 9) == 0) dma_lock = ~dma_lock;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Arbitrates one single-port synchronous data RAM between the CPU MEM stage and a DMA/debug requester. Sits between the MEM-stage memory interface and the RAM array. CPU has priority; a wait counter bounds DMA starvation, and a burst state machine bounds how long a locked DMA burst can hold off the CPU. It also suppresses CPU accesses killed by an exception or interrupt flush.

## Interface
- AW, 14, RAM byte-address width; RAM holds 2^(AW-2) words
- MAX_WAIT, 4, cycles a pending DMA request may lose to the CPU before it is forced through
- MAX_BURST, 8, consecutive locked DMA beats before the CPU is given one slot

- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  4  byte enables for writes
- cpu_addr  in  32  byte address; bits [AW-1:2] used
- cpu_wdata  in  32  write data
- cpu_kill  in  1  flush: the current CPU request is dropped
- cpu_stall  out  1  CPU request pending but not granted
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- dma_req, dma_we, dma_be[3:0], dma_addr[31:0], dma_wdata[31:0]  in  DMA request, same meaning as the CPU signals
- dma_lock  in  1  DMA requests burst ownership
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  32  DMA read data
- ram_en  out  1  RAM access this cycle
- ram_we  out  4  per-byte write strobes
- ram_addr  out  AW-2  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

## Operation
- Effective CPU request: cpu_req && !cpu_kill. A killed request gets no grant, no RAM access, no stall, and no rvalid.
- At most one grant per cycle. Grant is combinational from the current requests and registered state. The selected request drives ram_en, ram_addr, ram_wdata and ram_we (be when we=1, otherwise 0000).
- State ARB:
  - Only one requester active: it is granted.
  - Both active: CPU is granted unless wait_cnt == MAX_WAIT, in which case DMA is granted.
  - DMA granted with dma_lock=1: go to BURST and set beat_cnt=1.
- State BURST:
  - DMA is granted whenever dma_req is active, with priority over the CPU.
  - beat_cnt increments on each DMA grant.
  - dma_req=0 or dma_lock=0: return to ARB and grant per ARB rules in that same cycle.
  - beat_cnt == MAX_BURST and CPU effective request active: go to YIELD.
  - beat_cnt == MAX_BURST and no CPU request: the burst continues and beat_cnt saturates.
- State YIELD:
  - CPU is granted if requesting; DMA is not granted.
  - Next state is BURST with beat_cnt=0 if dma_lock is held, otherwise ARB.
  - A CPU kill during YIELD still consumes the slot.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each cycle dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or when dma_req=0.
- Read return:
  - A registered tag {valid, owner} records each read grant.
  - Next cycle, the owner's rvalid pulses for one cycle and its rdata = ram_rdata.
  - Writes produce no rvalid.
- cpu_stall = effective CPU request && !CPU grant.

## Timing
- Reset (reset=0 at posedge):
  - state=ARB, wait_cnt=0, beat_cnt=0, read tag cleared.
  - All outputs are 0 in the cycle after reset.
  - Reset during a burst aborts it, and any pending read return is discarded.
- Write latency: the RAM is updated at the posedge ending the grant cycle.
- Read latency: 1 cycle; rvalid follows the grant cycle.
- Back-to-back grants are allowed every cycle. Read-after-write to the same word in the next cycle returns the new data.
- DMA worst-case wait in ARB: MAX_WAIT cycles, granted on cycle MAX_WAIT+1.
- CPU worst-case wait while a DMA burst is locked: MAX_BURST beats, then one YIELD slot.
- cpu_kill acts in the same cycle: grant, RAM write and stall are all masked combinationally.

## Test plan
- Both requesters idle; CPU write addr 0x10, be=1111, data 0xDEADBEEF; CPU read 0x10 next cycle -> cpu_stall=0, cpu_rvalid pulses one cycle later with 0xDEADBEEF.
- CPU requests every cycle, DMA read 0x20 held (MAX_WAIT=4) -> dma_gnt=0 for 4 cycles, dma_gnt=1 on cycle 5, cpu_stall=1 exactly in that cycle, wait_cnt back to 0.
- DMA locked burst of 12 writes, CPU requesting throughout (MAX_BURST=8) -> 8 DMA grants, 1 CPU grant (YIELD), then remaining 4 DMA beats; cpu_stall high for 8 cycles.
- CPU write 0x30 with cpu_kill=1 -> ram_en=0, ram_we=0000, cpu_stall=0; a later read of 0x30 returns the old value.
- DMA read granted, reset=0 asserted in the following cycle -> no dma_rvalid, state ARB, all outputs 0.
- Byte write be=0100, data 0x00AB0000 to a word holding 0x11223344 -> readback 0x11AB3344.
